multicycle_control_unit: RTL and testbench

- Next-generation controller for the MIPS datapath: multicycle Moore FSM replacing the single-cycle opcode decoder.
- Sequences FETCH/DECODE/execute/writeback steps.
- Inserts a parametrised number of memory wait cycles.
- Embeds the ALU decoder; flags unsupported opcodes and functs.

---
 rtl/multicycle_control_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multicycle Moore controller for the MIPS datapath. It steps each instruction
// through FETCH/DECODE, an execute step and a writeback step. It adds
// MEM_LATENCY cycles to every memory access (FETCH, MEMRD, MEMWR). The ALU
// decoder is built in. Unsupported opcodes and functs are flagged on
// illegal_op.
//
// Optional feature (macro MC_CTRL_IMM_LOGIC_EN):
//   defined   : andi (001100) / ori (001101) run through ADDIEXE/ADDIWB, with
//               alu_control set to and/or.
//   undefined : andi/ori are illegal opcodes.
//
// Parameters:
//   MEM_LATENCY  cycles per memory access, 1..15
//   CNT_W        wait-counter width, 2**CNT_W > MEM_LATENCY
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   opcode       instr[31:26] from the instruction register
//   funct        instr[5:0]
//   zero         ALU zero flag (used in BRANCH)
//   mem_write    data memory write strobe
//   ir_write     instruction register load strobe
//   pc_write     unconditional PC load
//   pc_en        pc_write | (branch & zero)
//   branch       BRANCH state indicator
//   i_or_d       memory address select (0 PC, 1 ALUOut)
//   memto_reg    writeback data from memory
//   reg_dst      destination select (1 rd, 0 rt)
//   reg_write    register file write enable
//   alu_src_a    ALU A select (0 PC, 1 reg A)
//   alu_src_b    ALU B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   pc_src       PC source (00 ALU, 01 ALUOut, 10 jump target)
//   alu_control  010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal_op   one-cycle flag for an unsupported opcode or funct
//   state        current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned CNT_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_en,
   output logic       branch,
   output logic       i_or_d,
   output logic       memto_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_control,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_EXECUTE = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH  = 4'd8,  S_ADDIEXE = 4'd9,  S_ADDIWB  = 4'd10, S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_IMM_LOGIC_EN
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_last;
   logic             mem_write_raw, ir_write_raw, pc_write_raw, reg_write_raw;
   logic             branch_raw, illegal_raw;

   assign cnt_last = (cnt_q == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Only the wait states loop on themselves, so any state change clears the
   // counter. That clears it on entry to FETCH, MEMRD and MEMWR.
   assign cnt_d = (state_d == state_q) ? cnt_q + CNT_W'(1) : '0;

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a value held and no latch is inferred.
   always_comb begin
      state_d       = S_FETCH;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      pc_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      branch_raw    = 1'b0;
      illegal_raw   = 1'b0;
      i_or_d        = 1'b0;
      memto_reg     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_src        = 2'b00;
      alu_control   = 3'b000;

      case (state_q)
         S_FETCH: begin
            alu_src_b   = 2'b01;
            alu_control = ALU_ADD;
            if (cnt_last) begin
               ir_write_raw = 1'b1;
               pc_write_raw = 1'b1;
               state_d      = S_DECODE;
            end else begin
               state_d      = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_b   = 2'b11;
            alu_control = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXE;
`ifdef MC_CTRL_IMM_LOGIC_EN
               OP_ANDI,
               OP_ORI:       state_d = S_ADDIEXE;
`endif
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal_raw = 1'b1;
                  state_d     = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = ALU_ADD;
            state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            i_or_d  = 1'b1;
            state_d = cnt_last ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            memto_reg     = 1'b1;
            reg_write_raw = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEMWR: begin
            i_or_d = 1'b1;
            if (cnt_last) begin
               mem_write_raw = 1'b1;
               state_d       = S_FETCH;
            end else begin
               state_d       = S_MEMWR;
            end
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            state_d   = S_ALUWB;
            case (funct)
               6'b100000: alu_control = ALU_ADD;
               6'b100010: alu_control = ALU_SUB;
               6'b100100: alu_control = ALU_AND;
               6'b100101: alu_control = ALU_OR;
               6'b101010: alu_control = ALU_SLT;
               default: begin
                  alu_control = ALU_ADD;
                  illegal_raw = 1'b1;
               end
            endcase
         end
         S_ALUWB: begin
            reg_dst       = 1'b1;
            reg_write_raw = 1'b1;
            state_d       = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = 2'b01;
            branch_raw  = 1'b1;
            state_d     = S_FETCH;
         end
         S_ADDIEXE: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = ALU_ADD;
`ifdef MC_CTRL_IMM_LOGIC_EN
            if (opcode == OP_ANDI)     alu_control = ALU_AND;
            else if (opcode == OP_ORI) alu_control = ALU_OR;
`endif
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_raw = 1'b1;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_src       = 2'b10;
            pc_write_raw = 1'b1;
            state_d      = S_FETCH;
         end
         default: state_d = S_FETCH;  // unused codes 12-15
      endcase
   end

   // NOTE: reset only clears the state and the counter. While reset is high,
   // FETCH is current and its final-cycle strobes could still decode, so the
   // strobes are also masked directly by reset.
   assign mem_write  = mem_write_raw & ~reset;
   assign ir_write   = ir_write_raw  & ~reset;
   assign pc_write   = pc_write_raw  & ~reset;
   assign reg_write  = reg_write_raw & ~reset;
   assign branch     = branch_raw    & ~reset;
   assign illegal_op = illegal_raw   & ~reset;
   assign pc_en      = pc_write | (branch & zero);
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Builds two controllers, with MEM_LATENCY = 1 and MEM_LATENCY = 3. The
// driver runs each one in turn, with the other held in reset. For every
// instruction it issues, it expands the instruction into the expected
// per-cycle outputs and queues them. A separate monitor pops one entry per
// cycle and compares it on the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

   typedef struct packed {
      logic [3:0] state;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       pc_en;
      logic       branch;
      logic       i_or_d;
      logic       memto_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_control;
      logic       illegal_op;
   } obs_t;

   typedef struct {
      int   k;
      obs_t o;
   } item_t;

   typedef enum int {C_LW, C_SW, C_R, C_BEQ, C_IMM, C_J, C_ILL} cls_t;

   localparam logic [5:0] OP_TAB [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                         6'b001000, 6'b000010, 6'b001100, 6'b001101};
   localparam logic [5:0] FN_TAB [5] = '{6'b100000, 6'b100010, 6'b100100,
                                         6'b100101, 6'b101010};

   logic       clk;
   logic       rst  [2];
   logic [5:0] opc  [2];
   logic [5:0] fn   [2];
   logic       zero [2];
   obs_t       act  [2];

   item_t exp_q[$];
   int    n_cmp  = 0;
   int    n_fail = 0;
   int    cur_k;
   int    cur_lat;
   logic  drv_done = 1'b0;
   logic  mon_done = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 1 : 3;
      logic [3:0] st;
      logic       mw, irw, pcw, pce, br, iod, m2r, rdst, rw, asa, ill;
      logic [1:0] asb, pcs;
      logic [2:0] ac;

      multicycle_control_unit #(.MEM_LATENCY(LAT), .CNT_W(4)) u_dut (
         .clk(clk), .reset(rst[g]), .opcode(opc[g]), .funct(fn[g]), .zero(zero[g]),
         .mem_write(mw), .ir_write(irw), .pc_write(pcw), .pc_en(pce), .branch(br),
         .i_or_d(iod), .memto_reg(m2r), .reg_dst(rdst), .reg_write(rw),
         .alu_src_a(asa), .alu_src_b(asb), .pc_src(pcs), .alu_control(ac),
         .illegal_op(ill), .state(st)
      );

      assign act[g] = {st, mw, irw, pcw, pce, br, iod, m2r, rdst, rw, asa, asb, pcs, ac, ill};
   end

   // ---------------- reference model ----------------
   function automatic cls_t classify(input logic [5:0] op);
      case (op)
         6'b100011: return C_LW;
         6'b101011: return C_SW;
         6'b000000: return C_R;
         6'b000100: return C_BEQ;
         6'b001000: return C_IMM;
         6'b000010: return C_J;
`ifdef MC_CTRL_IMM_LOGIC_EN
         6'b001100, 6'b001101: return C_IMM;
`endif
         default:   return C_ILL;
      endcase
   endfunction

   function automatic obs_t base(input logic [3:0] s);
      obs_t o;
      o = '0;
      o.state = s;
      return o;
   endfunction

   // While reset is held the unit sits in FETCH with no strobes.
   function automatic obs_t fetch_obs(input logic last);
      obs_t o;
      o = base(4'd0);
      o.alu_src_b   = 2'b01;
      o.alu_control = 3'b010;
      o.ir_write    = last;
      o.pc_write    = last;
      o.pc_en       = last;
      return o;
   endfunction

   task automatic emit(input obs_t o);
      exp_q.push_back('{cur_k, o});
      @(posedge clk);
      #1;
   endtask

   task automatic reset_for(input int n);
      rst[cur_k] = 1'b1;
      repeat (n) emit(fetch_obs(1'b0));
      rst[cur_k] = 1'b0;
   endtask

   task automatic fetch_decode(input logic [5:0] op);
      obs_t o;
      for (int i = 0; i < cur_lat; i++) emit(fetch_obs(i == cur_lat - 1));
      o = base(4'd1);
      o.alu_src_b   = 2'b11;
      o.alu_control = 3'b010;
      o.illegal_op  = (classify(op) == C_ILL);
      emit(o);
   endtask

   function automatic obs_t memadr_obs();
      obs_t o;
      o = base(4'd2);
      o.alu_src_a   = 1'b1;
      o.alu_src_b   = 2'b10;
      o.alu_control = 3'b010;
      return o;
   endfunction

   task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
      obs_t o;
      opc[cur_k]  = op;
      fn[cur_k]   = f;
      zero[cur_k] = z;
      fetch_decode(op);
      case (classify(op))
         C_LW: begin
            emit(memadr_obs());
            for (int i = 0; i < cur_lat; i++) begin
               o = base(4'd3); o.i_or_d = 1'b1; emit(o);
            end
            o = base(4'd4); o.memto_reg = 1'b1; o.reg_write = 1'b1; emit(o);
         end
         C_SW: begin
            emit(memadr_obs());
            for (int i = 0; i < cur_lat; i++) begin
               o = base(4'd5); o.i_or_d = 1'b1; o.mem_write = (i == cur_lat - 1); emit(o);
            end
         end
         C_R: begin
            o = base(4'd6);
            o.alu_src_a = 1'b1;
            case (f)
               6'b100000: o.alu_control = 3'b010;
               6'b100010: o.alu_control = 3'b110;
               6'b100100: o.alu_control = 3'b000;
               6'b100101: o.alu_control = 3'b001;
               6'b101010: o.alu_control = 3'b111;
               default: begin o.alu_control = 3'b010; o.illegal_op = 1'b1; end
            endcase
            emit(o);
            o = base(4'd7); o.reg_dst = 1'b1; o.reg_write = 1'b1; emit(o);
         end
         C_BEQ: begin
            o = base(4'd8);
            o.alu_src_a = 1'b1; o.alu_control = 3'b110; o.pc_src = 2'b01;
            o.branch = 1'b1; o.pc_en = z;
            emit(o);
         end
         C_IMM: begin
            o = memadr_obs();
            o.state = 4'd9;
            if (op == 6'b001100) o.alu_control = 3'b000;
            else if (op == 6'b001101) o.alu_control = 3'b001;
            emit(o);
            o = base(4'd10); o.reg_write = 1'b1; emit(o);
         end
         C_J: begin
            o = base(4'd11); o.pc_src = 2'b10; o.pc_write = 1'b1; o.pc_en = 1'b1; emit(o);
         end
         default: ;  // illegal opcode: back to FETCH straight after DECODE
      endcase
   endtask

   // Reset arrives in the first MEMWR cycle of a store, before its final cycle.
   task automatic abort_store();
      obs_t o;
      opc[cur_k] = 6'b101011;
      fetch_decode(6'b101011);
      emit(memadr_obs());
      o = base(4'd5); o.i_or_d = 1'b1; emit(o);
      reset_for(2);
      run_instr(6'b100011, 6'b0, 1'b0);
   endtask

   // ---------------- driver ----------------
   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; opc[k] = '0; fn[k] = '0; zero[k] = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         cur_k   = k;
         cur_lat = (k == 0) ? 1 : 3;
         reset_for(2);
         run_instr(6'b100011, 6'h00, 1'b0);   // lw
         run_instr(6'b101011, 6'h00, 1'b0);   // sw
         run_instr(6'b000100, 6'h00, 1'b1);   // beq taken
         run_instr(6'b000100, 6'h00, 1'b0);   // beq not taken
         run_instr(6'b000000, 6'b101010, 1'b0);
         run_instr(6'b000000, 6'b000000, 1'b0);
         run_instr(6'b111111, 6'h00, 1'b0);
         run_instr(6'b001101, 6'h00, 1'b0);
         run_instr(6'b001100, 6'h00, 1'b0);
         run_instr(6'b001000, 6'h00, 1'b0);
         run_instr(6'b000010, 6'h00, 1'b0);
         for (int n = 0; n < 40; n++) begin
            logic [5:0] op, f;
            int         sel;
            sel = $urandom_range(0, 9);
            op  = (sel < 8) ? OP_TAB[sel] : 6'($urandom);
            f   = ($urandom_range(0, 3) != 0) ? FN_TAB[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(op, f, 1'($urandom));
         end
         if (cur_lat > 1) abort_store();
         rst[k] = 1'b1;
      end
      drv_done = 1'b1;
   end

   // ---------------- monitor ----------------
   task automatic check(input int k, input obs_t got, input obs_t want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL dut%0d outputs at %0t: got state=%0d vec=%h, want state=%0d vec=%h",
                  k, $time, got.state, got, want.state, want);
      end
   endtask

   initial begin
      item_t it;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            check(it.k, act[it.k], it.o);
         end else if (drv_done) begin
            break;
         end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard underflow at %0t: got empty queue, want an entry", $time);
         end
      end
      mon_done = 1'b1;
   end

   initial begin
      fork
         wait (mon_done);
         #2_000_000;
      join_any
      if (!mon_done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout: got monitor still running, want done");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
